// File: rtl/rs_enc_ctrl.sv
// Sequencing controller for a systematic RS encoder over GF(2^8): paces message symbols
// into the generator-tap chain, then drains the parity from the chain's top register.
module rs_enc_ctrl #(
  parameter int K      = 239,
  parameter int NPAR   = 16,
  parameter int DP_LAT = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,       // synchronous, active low
  input  logic       in_valid_i,
  input  logic [7:0] in_data_i,
  output logic       in_ready_o,
  input  logic [7:0] par_in_i,
  output logic [7:0] fb_sym_o,
  output logic       fb_en_o,
  output logic       out_valid_o,
  output logic [7:0] out_data_o,
  output logic       out_sop_o,
  output logic       out_eop_o,
  output logic       out_par_o,
  output logic       busy_o
);
  typedef enum logic [1:0] {IDLE, MSG, PAR} state_e;

  localparam logic [7:0] SYM_LAST = 8'(K - 1);
  localparam logic [4:0] PAR_LAST = 5'(NPAR - 1);
  localparam logic [1:0] GAP_LD   = 2'(DP_LAT - 1);

  state_e     state_q, state_d;
  logic [7:0] sym_cnt_q, sym_cnt_d;
  logic [4:0] par_cnt_q, par_cnt_d;
  logic [1:0] gap_cnt_q, gap_cnt_d;
  logic [7:0] fb_sym_q, fb_sym_d;
  logic [7:0] out_data_q, out_data_d;
  logic       fb_en_q, fb_en_d;
  logic       out_valid_q, out_valid_d;
  logic       out_sop_q, out_sop_d;
  logic       out_eop_q, out_eop_d;
  logic       out_par_q, out_par_d;
  logic       xfer, par_issue;

  // Gated by reset so the source sees no ready while the chain is being cleared.
  assign in_ready_o = rst_i && (state_q == IDLE || state_q == MSG) && (gap_cnt_q == 2'd0);

  always_comb begin
    state_d     = state_q;
    sym_cnt_d   = sym_cnt_q;
    par_cnt_d   = par_cnt_q;
    gap_cnt_d   = (gap_cnt_q != 2'd0) ? gap_cnt_q - 2'd1 : 2'd0;
    fb_sym_d    = 8'h00;
    fb_en_d     = 1'b0;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_sop_d   = 1'b0;
    out_eop_d   = 1'b0;
    out_par_d   = 1'b0;
    xfer        = in_valid_i && in_ready_o;
    par_issue   = (state_q == PAR) && (gap_cnt_q == 2'd0);

    if (xfer) begin
      fb_sym_d    = in_data_i ^ par_in_i;
      fb_en_d     = 1'b1;
      out_valid_d = 1'b1;
      out_data_d  = in_data_i;
      out_sop_d   = (sym_cnt_q == 8'd0);
      gap_cnt_d   = GAP_LD;
      sym_cnt_d   = sym_cnt_q + 8'd1;
      state_d     = (sym_cnt_q == SYM_LAST) ? PAR : MSG;
    end else if (par_issue) begin
      // Zero feedback shifts the chain; after NPAR shifts it is all zeros again.
      fb_en_d     = 1'b1;
      out_valid_d = 1'b1;
      out_data_d  = par_in_i;
      out_par_d   = 1'b1;
      out_eop_d   = (par_cnt_q == PAR_LAST);
      gap_cnt_d   = GAP_LD;
      if (par_cnt_q == PAR_LAST) begin
        state_d   = IDLE;
        sym_cnt_d = 8'd0;
        par_cnt_d = 5'd0;
      end else begin
        par_cnt_d = par_cnt_q + 5'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      sym_cnt_q   <= 8'd0;
      par_cnt_q   <= 5'd0;
      gap_cnt_q   <= 2'd0;
      fb_sym_q    <= 8'h00;
      fb_en_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_par_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sym_cnt_q   <= sym_cnt_d;
      par_cnt_q   <= par_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      fb_sym_q    <= fb_sym_d;
      fb_en_q     <= fb_en_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      out_par_q   <= out_par_d;
    end
  end

  assign fb_sym_o    = fb_sym_q;
  assign fb_en_o     = fb_en_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_sop_o   = out_sop_q;
  assign out_eop_o   = out_eop_q;
  assign out_par_o   = out_par_q;
  // Held through the eop cycle even though the FSM is already back in IDLE.
  assign busy_o      = (state_q != IDLE) || out_eop_q;

endmodule

// File: tb/tb_rs_enc_ctrl.sv
// Scoreboard bench for rs_enc_ctrl: two configurations, each driving a behavioural
// generator-tap chain and checked against a long-division RS parity model.
module tb_rs_enc_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] d;
    logic sop, eop, par, lastmsg, tight, b2b, fbz;
  } exp_t;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, x;
    r = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1d) : (x << 1);
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic abort_run(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: handshake never completed", nm);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "bench stopped on timeout");
  endtask

  for (genvar c = 0; c < 2; c++) begin : g_cfg
    localparam int K    = (c == 0) ? 239 : 11;
    localparam int NPAR = (c == 0) ? 16 : 4;
    localparam int DP   = (c == 0) ? 2 : 1;
    localparam int PART = (c == 0) ? 100 : 5;

    logic       rst = 1'b0, in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready, fb_en, out_valid, out_sop, out_eop, out_par, busy;
    logic [7:0] par_in, fb_sym, out_data;
    logic [7:0] ghd  [NPAR+1];
    logic [7:0] gl   [NPAR];
    logic [7:0] creg [NPAR];
    logic [7:0] msg  [K];
    logic [7:0] a    [K+NPAR];
    exp_t       q [$];
    int         last_cyc, eop_cyc, viol;
    logic       in_par;
    bit         done = 1'b0;

    rs_enc_ctrl #(.K(K), .NPAR(NPAR), .DP_LAT(DP)) dut (
      .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_data_i(in_data),
      .in_ready_o(in_ready), .par_in_i(par_in), .fb_sym_o(fb_sym), .fb_en_o(fb_en),
      .out_valid_o(out_valid), .out_data_o(out_data), .out_sop_o(out_sop),
      .out_eop_o(out_eop), .out_par_o(out_par), .busy_o(busy));

    // Tap chain: registers update on the edge after an issue; with DP=1 the top
    // register's next value is presented early so a back-to-back issue sees it.
    initial forever begin
      @(posedge clk);
      if (!rst) begin
        for (int j = 0; j < NPAR; j++) creg[j] <= 8'h00;
      end else if (fb_en) begin
        creg[0] <= gf_mul(fb_sym, gl[0]);
        for (int j = 1; j < NPAR; j++) creg[j] <= creg[j-1] ^ gf_mul(fb_sym, gl[j]);
      end
    end
    assign par_in = (DP == 1 && fb_en) ? (creg[NPAR-2] ^ gf_mul(fb_sym, gl[NPAR-1]))
                                       : creg[NPAR-1];

    // g(x) = prod (x + alpha^i), i = 0..NPAR-1, highest degree first in ghd.
    task automatic make_gen();
      logic [7:0] r;
      r = 8'h01;
      for (int k = 0; k <= NPAR; k++) ghd[k] = (k == 0) ? 8'h01 : 8'h00;
      for (int i = 0; i < NPAR; i++) begin
        for (int k = i + 1; k >= 1; k--) ghd[k] = ghd[k] ^ gf_mul(r, ghd[k-1]);
        r = gf_mul(r, 8'h02);
      end
      for (int j = 0; j < NPAR; j++) gl[j] = ghd[NPAR-j];
    endtask

    task automatic push_frame(input int nsym, input bit gaps, input bit b2b, input bit zf);
      exp_t e;
      logic [7:0] cf;
      for (int i = 0; i < K + NPAR; i++) a[i] = (i < K) ? msg[i] : 8'h00;
      for (int i = 0; i < K; i++) begin
        cf = a[i];
        for (int j = 1; j <= NPAR; j++) a[i+j] = a[i+j] ^ gf_mul(cf, ghd[j]);
      end
      for (int i = 0; i < nsym; i++) begin
        e.d       = (i < K) ? msg[i] : a[i];
        e.sop     = (i == 0);
        e.eop     = (i == K + NPAR - 1);
        e.par     = (i >= K);
        e.lastmsg = (i == K - 1);
        e.tight   = (i != 0) && (!gaps || i >= K);
        e.b2b     = (i == 0) && b2b;
        e.fbz     = (i >= K) || zf;
        q.push_back(e);
      end
    endtask

    task automatic send(input logic [7:0] d, input bit gaps);
      int n;
      n = 0;
      while (gaps && $urandom_range(0, 99) < 30) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = d;
      while (!in_ready && n < 64) begin
        @(negedge clk);
        n++;
      end
      if (n >= 64) abort_run($sformatf("cfg%0d_ready_wait", c));
      @(negedge clk);
    endtask

    task automatic wait_idle();
      int n;
      n = 0;
      in_valid = 1'b0;
      while ((q.size() != 0 || busy) && n < 2000) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("cfg%0d_drain", c), {31'd0, q.size() == 0 && !busy}, 32'd1);
    endtask

    task automatic check_rst_outs();
      chk($sformatf("cfg%0d_rst_ready", c), {31'd0, in_ready}, 32'd0);
      chk($sformatf("cfg%0d_rst_strobes", c),
          {27'd0, fb_en, out_valid, out_sop, out_eop, out_par}, 32'd0);
      chk($sformatf("cfg%0d_rst_data", c), {16'd0, out_data, fb_sym}, 32'd0);
      chk($sformatf("cfg%0d_rst_busy", c), {31'd0, busy}, 32'd0);
    endtask

    initial begin
      make_gen();
      repeat (3) @(negedge clk);
      check_rst_outs();
      rst = 1'b1;
      @(negedge clk);
      chk($sformatf("cfg%0d_ready_after_rst", c), {31'd0, in_ready}, 32'd1);

      for (int i = 0; i < K; i++) msg[i] = 8'(i + c);
      push_frame(K + NPAR, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < K; i++) send(msg[i], 1'b0);
      wait_idle();

      for (int i = 0; i < K; i++) msg[i] = 8'h00;
      push_frame(K + NPAR, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < K; i++) send(msg[i], 1'b0);
      wait_idle();

      for (int i = 0; i < K; i++) msg[i] = 8'($urandom_range(0, 255));
      push_frame(K + NPAR, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < K; i++) send(msg[i], 1'b1);
      wait_idle();

      for (int f = 0; f < 3; f++) begin
        for (int i = 0; i < K; i++) msg[i] = 8'($urandom_range(0, 255));
        push_frame(K + NPAR, 1'b0, f > 0, 1'b0);
        for (int i = 0; i < K; i++) send(msg[i], 1'b0);
      end
      wait_idle();

      for (int i = 0; i < K; i++) msg[i] = 8'($urandom_range(1, 255));
      push_frame(PART, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < PART; i++) send(msg[i], 1'b0);
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check_rst_outs();
      chk($sformatf("cfg%0d_partial_drained", c), q.size(), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      chk($sformatf("cfg%0d_ready_after_rst2", c), {31'd0, in_ready}, 32'd1);

      for (int i = 0; i < K; i++) msg[i] = 8'($urandom_range(0, 255));
      push_frame(K + NPAR, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < K; i++) send(msg[i], 1'b0);
      wait_idle();
      done = 1'b1;
    end

    initial begin
      exp_t e;
      last_cyc = -1000;
      eop_cyc  = -1000;
      viol     = 0;
      in_par   = 1'b0;
      forever begin
        @(negedge clk);
        if (!rst) begin
          last_cyc = -1000;
          eop_cyc  = -1000;
          viol     = 0;
          in_par   = 1'b0;
        end else begin
          if (fb_en !== out_valid) viol++;
          if (!out_valid && (out_sop || out_eop || out_par || fb_sym != 8'h00)) viol++;
          if (out_valid) begin
            if (!busy) viol++;
            if (cyc - last_cyc < DP) viol++;
            if (q.size() == 0) begin
              tests++;
              fails++;
              $display("FAIL cfg%0d_unexpected_out: got data 0x%0h, expected no output", c, out_data);
            end else begin
              e = q.pop_front();
              chk($sformatf("cfg%0d_sym", c), {21'd0, out_data, out_sop, out_eop, out_par},
                  {21'd0, e.d, e.sop, e.eop, e.par});
              if (e.fbz) chk($sformatf("cfg%0d_fb_zero", c), {24'd0, fb_sym}, 32'd0);
              if (e.tight) chk($sformatf("cfg%0d_spacing", c), cyc - last_cyc, DP);
              if (e.b2b) chk($sformatf("cfg%0d_frame_gap", c), cyc - eop_cyc, DP);
              if (e.lastmsg) in_par = 1'b1;
            end
            last_cyc = cyc;
          end
          if (in_par && !out_eop && in_ready) viol++;
          if (out_valid && out_eop) begin
            chk($sformatf("cfg%0d_frame_rules", c), viol, 32'd0);
            viol    = 0;
            in_par  = 1'b0;
            eop_cyc = cyc;
          end
        end
      end
    end
  end

  initial begin
    int n;
    n = 0;
    while (!(g_cfg[0].done && g_cfg[1].done) && n < 80000) begin
      @(negedge clk);
      n++;
    end
    chk("all_done", {31'd0, g_cfg[0].done && g_cfg[1].done}, 32'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rs_enc_ctrl.md
# rs_enc_ctrl

Sequencing controller for the systematic RS(255,239) encoder over GF(2^8).
- Accepts message symbols through a valid/ready handshake and computes the feedback symbol for the generator-tap chain.
- Paces each symbol issue to the chain's pipeline latency, then drains the NPAR parity symbols from the top remainder register.
- Emits the complete codeword as a framed symbol stream.
- Sits between the framer/source and the `mux_*` tap-stage chain. The chain's register updates are qualified by `fb_en`.

## Interface
Parameters:
- `K`, 239, message symbols per codeword (1..247)
- `NPAR`, 16, parity symbols per codeword (2..16); K+NPAR ≤ 255
- `DP_LAT`, 2, clocks the tap chain needs from feedback in to an updated `par_in` (1..4)

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  synchronous, active-low reset
- `in_valid`  in  1  message symbol available
- `in_data`  in  8  message symbol
- `in_ready`  out  1  controller accepts `in_data` this cycle
- `par_in`  in  8  highest-degree remainder register of the tap chain
- `fb_sym`  out  8  feedback symbol (mr) to all tap stages
- `fb_en`  out  1  tap-chain update strobe, one cycle per issued symbol
- `out_valid`  out  1  codeword symbol strobe
- `out_data`  out  8  codeword symbol
- `out_sop`  out  1  first symbol of codeword
- `out_eop`  out  1  last parity symbol
- `out_par`  out  1  `out_data` is a parity symbol
- `busy`  out  1  frame in progress

## Operation
- States:
  - IDLE → MSG on the first transfer.
  - MSG → PAR after the K-th transfer.
  - PAR → IDLE after the NPAR-th parity issue.
- Transfer occurs when `in_valid` & `in_ready`.
- `in_ready` = (state IDLE or MSG) & `gap_cnt`==0. It is low throughout PAR.
- On each message transfer (registered):
  - `fb_sym` <= `in_data` ^ `par_in`
  - `fb_en` <= 1
  - `out_data` <= `in_data`, `out_valid` <= 1, `out_par` <= 0
  - `out_sop` <= (`sym_cnt`==0)
  - `sym_cnt` increments.
- On each parity issue (registered):
  - `out_data` <= `par_in`, `fb_sym` <= 0, `fb_en` <= 1
  - `out_valid` <= 1, `out_par` <= 1
  - `out_eop` <= (`par_cnt`==NPAR-1)
  - `par_cnt` increments.
- Zero feedback turns the chain into a plain shift register. After NPAR parity shifts the chain holds all zeros, so no explicit clear is needed between frames.
- `gap_cnt` loads DP_LAT-1 on every issue and decrements to 0. No issue of either kind occurs while `gap_cnt`≠0.
- Parity issue in PAR fires whenever `gap_cnt`==0. It is independent of `in_valid`.
- When not issuing, `fb_en`, `out_valid`, `out_sop`, `out_eop` and `out_par` are 0 and `fb_sym` is 0. `out_data` holds its last value.
- `busy` = 1 from the cycle after the first transfer through the cycle `out_eop` is high. It is 0 in IDLE otherwise.
- Counter widths: `sym_cnt` 8 bits, `par_cnt` 5 bits, `gap_cnt` 2 bits. All clear on frame end.
- Reset mid-frame (`rst`=0 at any edge):
  - state → IDLE; all counters → 0.
  - All outputs → 0, except `in_ready`, which is 1 in the first cycle after reset release.
  - The partial frame is discarded. The tap chain is reset by the same `rst`.
- `in_valid` low while in MSG: the controller waits indefinitely. `gap_cnt` still counts down.

## Timing
- Reset values: `in_ready`=0 while `rst`=0. All other outputs are 0.
- Latency: a transfer at edge t drives `out_valid`/`fb_en` high in cycle t+1, for exactly 1 cycle.
- Issue spacing: the next issue (transfer or parity) occurs no earlier than edge t+DP_LAT. With DP_LAT=1, issues can be back-to-back.
- The first parity issue occurs DP_LAT edges after the K-th transfer, so `par_in` already includes the last message symbol.
- Minimum codeword duration: (K+NPAR)·DP_LAT cycles.
- Next-frame acceptance: `in_ready` may be 1 in the same cycle `out_eop` is high, once `gap_cnt`==0.
  - That is, the earliest next transfer is DP_LAT edges after the last parity issue.
- `fb_sym` and `fb_en` change only on issue edges. The tap chain samples them on the following edge.

## Test plan
- K=239, NPAR=16, DP_LAT=2, `in_valid`=1, `in_data`=0..238 → `out_data` repeats the message, then 16 parity symbols matching the golden RS(255,239) model. `out_sop` is on symbol 0, `out_eop` on symbol 254, and one symbol is output every 2 cycles.
- All-zero message → all 16 parity symbols = 0x00, `out_par`=1 exactly on the final 16 strobes, `fb_sym` always 0.
- Random `in_valid` gaps (30% idle) with random data → codeword identical to the gap-free run. No issue ever occurs closer than DP_LAT cycles to the previous one, and `in_ready`=0 throughout PAR.
- Three back-to-back frames with `in_valid` held 1 → the first transfer of frame n+1 occurs exactly DP_LAT edges after the last parity issue of frame n, and each frame's parity matches the model (checks the implicit chain clear).
- `rst` pulled low at message symbol 100, then a full frame is sent → all outputs are 0 during reset. After release the new frame encodes correctly, `out_sop` is on its first symbol, and nothing from the partial frame appears.
- DP_LAT=1, K=11, NPAR=4 (RS(15,11) subset test with matching chain) → back-to-back issues, 15 consecutive `out_valid` cycles, parity matches the model.
